clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Programmable clock-enable divider and period monitor. It produces a divided square wave `div_out` from `clk`, with half-period set at run time. It sequences start, stop and configuration changes so that they land only on period boundaries, and it self-measures the period of its own output. It sits between the control/config logic and any block needing a slow, glitch-free periodic strobe.

## Interface
- `CNT_W`, 8, width of half-period config and phase counter
- `clk`  in  1  single system clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `cfg_valid`  in  1  new half-period offered
- `cfg_half`  in  CNT_W  requested half-period in clk cycles; 0 treated as 1
- `cfg_ready`  out  1  config can be accepted this cycle
- `start`  in  1  request to begin generation (level-sampled)
- `stop`  in  1  request to end generation (level-sampled)
- `div_out`  out  1  divided square wave, high H cycles then low H cycles
- `tick`  out  1  one-cycle pulse coincident with every rising edge of `div_out`
- `running`  out  1  generator active (RUN or STOP_PEND)
- `meas_valid`  out  1  one-cycle pulse, `meas_period` updated
- `meas_period`  out  CNT_W+1  clk cycles between the last two rising edges of `div_out`

## Operation
- States: IDLE, RUN, STOP_PEND.
- Reset: IDLE; `div_out`=0, `tick`=0, `running`=0, `meas_valid`=0, `meas_period`=0, `cfg_ready`=1, active half H=1, no pending config.
- Config:
  - In IDLE, a `cfg_valid` handshake (`cfg_valid && cfg_ready`) loads H directly.
  - In RUN or STOP_PEND, the handshake stores the value as pending and drops `cfg_ready` until the pending value is applied.
  - The pending value is applied at the next rising edge of `div_out`; the new H governs the high phase beginning there.
- IDLE → RUN on `start` with `stop`=0.
  - Next cycle: `div_out`=1, `tick`=1, phase counter=H-1.
- RUN: the phase counter decrements each cycle. At 0, `div_out` toggles and the counter reloads H-1.
- RUN → STOP_PEND on `stop`.
  - If `div_out`=0, go straight to IDLE next cycle with `div_out` held 0.
  - Otherwise finish the current high phase. At the high→low toggle go to IDLE; `div_out` stays 0.
- No partial high pulses are ever emitted.
- `start` and `stop` in the same cycle: `stop` wins. `start` in RUN or STOP_PEND is ignored.
- Pending config is discarded on reset only; it survives a stop and is loaded as H on entry to IDLE.
- Measurement:
  - The first `tick` after entering RUN only arms the meter.
  - Each later `tick` loads `meas_period` with cycles since the previous `tick` and pulses `meas_valid`.
  - The meter disarms on entry to IDLE.
  - The count saturates at 2^(CNT_W+1)-1.
- Synchronous reset mid-operation returns all outputs to reset values on the next edge, regardless of state.

## Timing
- `start` sampled at cycle t → `running`=1, `div_out`=1, `tick`=1 at t+1.
- Rising edges of `div_out` at t+1+2kH; falling edges at t+1+(2k+1)H.
- First `meas_valid` at t+1+2H with `meas_period`=2H.
- Config handshake at cycle c while running: the value is applied on the first rising edge after c. That measured period still reports 2·H_old. The following one reports 2·H_new.
- `cfg_ready` returns to 1 in the cycle after the pending value is applied.
- `tick`, `meas_valid`: exactly one cycle wide, registered, never asserted in IDLE.

## Structure
- Shared package `clk_div_pkg`: state enum (IDLE/RUN/STOP_PEND), default `CNT_W`, constant MIN_HALF=1.
- Sub-module `period_meter`: inputs `clk`, `rst`, `tick`, `arm_clr`; outputs `meas_valid`, `meas_period`. It holds the arm flag and the saturating counter.
- Top holds the FSM, phase counter and config holding register.

## Test plan
- Reset, then `cfg_half`=6 in IDLE, `start` at cycle 10 → `div_out` high cycles 11–16, low 17–22, `tick` at 11 and 23, `meas_valid` at 23 with `meas_period`=12.
- Run at H=6, config H=3 during the low phase → `cfg_ready`=0 until the next rising edge. The next measurement reads 12 and the following one 6.
- `stop` mid high phase (H=6) → `div_out` stays high until its 6th high cycle, then 0. `running`=0 the cycle after. No further `tick`.
- `start`+`stop` asserted together in IDLE → remains IDLE, all outputs 0. `cfg_half`=0 → H=1, period 2, `meas_period`=2.
- `rst` pulse during RUN → next cycle all outputs at reset values. A later `start` gives the first `meas_valid` only after two new ticks.
- CNT_W=8, H=255 → `meas_period`=510, no saturation. Bench also checks that `meas_valid` count equals `tick` count minus 1 per run.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-enable divider.
// Imported by clk_div_ctrl and period_meter.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    STOP_PEND = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 8;
  localparam int MIN_HALF  = 1;

endpackage

// File: rtl/period_meter.sv
// Measures clk cycles between successive ticks.
// First tick after arm_clr only arms; counter saturates.
module period_meter
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           arm_clr,
  output logic           meas_valid,
  output logic [CNT_W:0] meas_period
);

  localparam logic [CNT_W:0] SAT = '1;

  logic           armed;
  logic [CNT_W:0] cnt;

  // tick arrives one cycle ahead of the registered tick output,
  // so meas_valid lines up with the visible tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed       <= 1'b0;
      cnt         <= '0;
      meas_valid  <= 1'b0;
      meas_period <= '0;
    end else begin
      meas_valid <= tick && armed;
      if (tick) begin
        cnt   <= {{CNT_W{1'b0}}, 1'b1};
        armed <= 1'b1;
        if (armed) meas_period <= cnt;
      end else if (cnt != SAT) begin
        cnt <= cnt + 1'b1;
      end
      if (arm_clr) armed <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable divided square wave with boundary-aligned
// start/stop/config sequencing and self period measurement.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  output logic             div_out,
  output logic             tick,
  output logic             running,
  output logic             meas_valid,
  output logic [CNT_W:0]   meas_period
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] half, half_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] pend, pend_nxt;
  logic [CNT_W-1:0] cfg_h, rise_h;
  logic             pend_v, pend_v_nxt;
  logic             div_nxt, tick_nxt;
  logic             cfg_acc, arm_clr;

  assign cfg_ready = !pend_v;
  assign running   = (state != IDLE);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign cfg_h     = (cfg_half == '0) ? CNT_W'(MIN_HALF) : cfg_half;
  // H taken at a rising edge; a same-cycle handshake bypasses the holding reg
  assign rise_h    = pend_v ? pend : (cfg_acc ? cfg_h : half);

  always_comb begin
    state_nxt  = state;
    half_nxt   = half;
    cnt_nxt    = cnt;
    pend_nxt   = pend;
    pend_v_nxt = pend_v;
    div_nxt    = div_out;
    tick_nxt   = 1'b0;
    arm_clr    = 1'b0;
    if (cfg_acc) begin
      if (state == IDLE) begin
        half_nxt = cfg_h;
      end else begin
        pend_nxt   = cfg_h;
        pend_v_nxt = 1'b1;
      end
    end
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RUN;
          div_nxt   = 1'b1;
          tick_nxt  = 1'b1;
          cnt_nxt   = half_nxt - 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          if (!div_out || cnt == '0) begin
            state_nxt = IDLE;
            div_nxt   = 1'b0;
          end else begin
            state_nxt = STOP_PEND;
            cnt_nxt   = cnt - 1'b1;
          end
        end else if (cnt == '0) begin
          div_nxt = !div_out;
          if (!div_out) begin
            tick_nxt   = 1'b1;
            half_nxt   = rise_h;
            pend_v_nxt = 1'b0;
            cnt_nxt    = rise_h - 1'b1;
          end else begin
            cnt_nxt = half - 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STOP_PEND: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          div_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        div_nxt   = 1'b0;
      end
    endcase
    // A held config survives stop and becomes H on return to IDLE
    if (state != IDLE && state_nxt == IDLE) begin
      arm_clr = 1'b1;
      if (pend_v_nxt) begin
        half_nxt   = pend_nxt;
        pend_v_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      half    <= CNT_W'(MIN_HALF);
      cnt     <= '0;
      pend    <= '0;
      pend_v  <= 1'b0;
      div_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_nxt;
      half    <= half_nxt;
      cnt     <= cnt_nxt;
      pend    <= pend_nxt;
      pend_v  <= pend_v_nxt;
      div_out <= div_nxt;
      tick    <= tick_nxt;
    end
  end

  period_meter #(
    .CNT_W(CNT_W)
  ) u_meter (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick_nxt),
    .arm_clr    (arm_clr),
    .meas_valid (meas_valid),
    .meas_period(meas_period)
  );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: expected periods are queued
// at stimulus time and popped on each meas_valid.
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic           cfg_ready;
  logic           start;
  logic           stop;
  logic           div_out;
  logic           tick;
  logic           running;
  logic           meas_valid;
  logic [CNT_W:0] meas_period;

  int n_tests = 0;
  int n_fail  = 0;
  int tick_cnt = 0;
  int mv_cnt   = 0;
  int q[$];

  clk_div_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_half   (cfg_half),
    .cfg_ready  (cfg_ready),
    .start      (start),
    .stop       (stop),
    .div_out    (div_out),
    .tick       (tick),
    .running    (running),
    .meas_valid (meas_valid),
    .meas_period(meas_period)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input int h);
    cfg_valid = 1'b1;
    cfg_half  = CNT_W'(h);
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (running && n < lim) begin
      step();
      n++;
    end
    chk("idle_bound", running, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (tick) tick_cnt++;
      if (meas_valid) begin
        int exp;
        mv_cnt++;
        exp = (q.size() > 0) ? q.pop_front() : -1;
        chk("meas_period", meas_period, exp);
        chk("mv_with_tick", tick, 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, m0;
    rst = 1'b1; cfg_valid = 1'b0; cfg_half = '0;
    start = 1'b0; stop = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_div", div_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_run", running, 0);
    chk("rst_mv", meas_valid, 0);
    chk("rst_mp", meas_period, 0);
    chk("rst_rdy", cfg_ready, 1);

    // basic H=6 waveform, stop on the cycle before a rising edge
    do_cfg(6);
    t0 = tick_cnt; m0 = mv_cnt;
    q.push_back(12);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i <= 23; i++) begin
      chk("t1_div", div_out, int'(((i - 1) / 6) % 2 == 0));
      chk("t1_tick", tick, int'((i - 1) % 12 == 0));
      chk("t1_mv", meas_valid, int'(i == 13));
      step();
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk("t1_stop_div", div_out, 0);
    chk("t1_stop_tick", tick, 0);
    chk("t1_stop_run", running, 0);
    chk("t1_counts", mv_cnt - m0, tick_cnt - t0 - 1);

    // config change H 6->3 during the low phase
    q.push_back(12); q.push_back(12);
    start = 1'b1; step(); start = 1'b0;
    repeat (19) step();
    chk("t2_low", div_out, 0);
    chk("t2_rdy0", cfg_ready, 1);
    cfg_valid = 1'b1; cfg_half = 8'd3;
    q.push_back(6);
    step(); cfg_valid = 1'b0;
    chk("t2_rdy21", cfg_ready, 0);
    repeat (3) step();
    chk("t2_rdy24", cfg_ready, 0);
    step();
    chk("t2_tick25", tick, 1);
    chk("t2_div25", div_out, 1);
    step();
    chk("t2_rdy26", cfg_ready, 1);
    repeat (2) step();
    chk("t2_div28", div_out, 0);
    repeat (3) step();
    chk("t2_tick31", tick, 1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t2_mp", meas_period, 6);
    chk("t2_div32", div_out, 1);
    chk("t2_run32", running, 1);
    step();
    chk("t2_div33", div_out, 1);
    step();
    chk("t2_div34", div_out, 0);
    chk("t2_run34", running, 0);

    // stop mid high phase; pending H=2 loaded on return to IDLE
    do_cfg(6);
    chk("t3_rdy", cfg_ready, 1);
    start = 1'b1; step(); start = 1'b0;
    repeat (2) step();
    stop = 1'b1; cfg_valid = 1'b1; cfg_half = 8'd2;
    step();
    stop = 1'b0; cfg_valid = 1'b0;
    chk("t3_rdy4", cfg_ready, 0);
    for (int i = 4; i <= 6; i++) begin
      chk("t3_hold", div_out, 1);
      chk("t3_run", running, 1);
      chk("t3_tick", tick, 0);
      step();
    end
    chk("t3_div7", div_out, 0);
    chk("t3_run7", running, 0);
    chk("t3_rdy7", cfg_ready, 1);
    t0 = tick_cnt;
    repeat (15) step();
    chk("t3_notick", tick_cnt - t0, 0);
    q.push_back(4);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("t3_h2", div_out, int'(((i - 1) / 2) % 2 == 0));
      step();
    end
    chk("t3_tick5", tick, 1);
    stop = 1'b1; step(); stop = 1'b0;
    step();
    chk("t3_end", div_out, 0);
    chk("t3_endrun", running, 0);

    // start+stop together, then H=0 -> 1
    start = 1'b1; stop = 1'b1; step();
    start = 1'b0; stop = 1'b0;
    chk("t4_run", running, 0);
    chk("t4_div", div_out, 0);
    chk("t4_tick", tick, 0);
    step();
    chk("t4_run2", running, 0);
    do_cfg(0);
    q.push_back(2); q.push_back(2); q.push_back(2);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      chk("t4_h1", div_out, int'(i % 2 == 1));
      if (i < 7) step();
    end
    stop = 1'b1; step(); stop = 1'b0;
    chk("t4_div_end", div_out, 0);
    chk("t4_run_end", running, 0);
    chk("t4_mp", meas_period, 2);

    // reset pulse during RUN
    do_cfg(4);
    start = 1'b1; step(); start = 1'b0;
    repeat (4) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_div", div_out, 0);
    chk("t5_tick", tick, 0);
    chk("t5_run", running, 0);
    chk("t5_mv", meas_valid, 0);
    chk("t5_mp", meas_period, 0);
    chk("t5_rdy", cfg_ready, 1);
    q.push_back(2);
    start = 1'b1; step(); start = 1'b0;
    chk("t5_tick1", tick, 1);
    chk("t5_mv1", meas_valid, 0);
    step(); step();
    chk("t5_tick3", tick, 1);
    chk("t5_mv3", meas_valid, 1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("t5_idle", running, 0);

    // widest half period, no saturation
    do_cfg(255);
    t0 = tick_cnt; m0 = mv_cnt;
    q.push_back(510); q.push_back(510);
    start = 1'b1; step(); start = 1'b0;
    repeat (254) step();
    chk("t6_div255", div_out, 1);
    step();
    chk("t6_div256", div_out, 0);
    repeat (255) step();
    chk("t6_tick511", tick, 1);
    repeat (510) step();
    chk("t6_tick1021", tick, 1);
    stop = 1'b1; step(); stop = 1'b0;
    wait_idle(300);
    chk("t6_mp", meas_period, 510);
    chk("t6_counts", mv_cnt - m0, tick_cnt - t0 - 1);

    step();
    chk("q_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
